rv_inst_encoder: RTL and testbench



---
 rtl/rv_inst_encoder_pkg.sv | 94 +++++++++
 rtl/rv_inst_encoder_imm_pack.sv | 47 ++++
 rtl/rv_inst_encoder.sv | 212 +++++++++++++++++++++
 tb/tb_rv_inst_encoder.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_inst_encoder_pkg.sv
// Shared RV64I encoding definitions: encoder op enum, opcodes, funct fields.
// The decoder reuses the opcode and funct constants.
package rv_inst_encoder_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned IMM_W  = 64;

    typedef enum logic [5:0] {
        ENC_ADDI   = 6'd0,
        ENC_SLTI   = 6'd1,
        ENC_SLTIU  = 6'd2,
        ENC_ANDI   = 6'd3,
        ENC_ORI    = 6'd4,
        ENC_XORI   = 6'd5,
        ENC_SLLI   = 6'd6,
        ENC_SRLI   = 6'd7,
        ENC_SRAI   = 6'd8,
        ENC_JALR   = 6'd9,
        ENC_LD     = 6'd10,
        ENC_SD     = 6'd11,
        ENC_BEQ    = 6'd12,
        ENC_BNE    = 6'd13,
        ENC_BLT    = 6'd14,
        ENC_BGE    = 6'd15,
        ENC_BLTU   = 6'd16,
        ENC_BGEU   = 6'd17,
        ENC_JAL    = 6'd18,
        ENC_LUI    = 6'd19,
        ENC_AUIPC  = 6'd20,
        ENC_ADD    = 6'd21,
        ENC_SUB    = 6'd22,
        ENC_SLT    = 6'd23,
        ENC_SLTU   = 6'd24,
        ENC_AND    = 6'd25,
        ENC_OR     = 6'd26,
        ENC_XOR    = 6'd27,
        ENC_SLL    = 6'd28,
        ENC_SRL    = 6'd29,
        ENC_SRA    = 6'd30,
        ENC_EBREAK = 6'd31,
        ENC_LI     = 6'd32
    } enc_op_e;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_J, FMT_U, FMT_SYS
    } fmt_e;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_LD   = 3'b011;
    localparam logic [2:0] F3_SD   = 3'b011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
        logic        last;
    } enc_word_t;

    // True when v is representable as an n-bit two's complement value.
    function automatic logic fits_signed(input logic [63:0] v, input int unsigned n);
        logic [63:0] s;
        s = 64'($signed(v) >>> (n - 1));
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/rv_inst_encoder_imm_pack.sv
// Scatters an immediate into its RV64I instruction-format bit positions and
// reports whether the value is encodable in that format.
module rv_imm_pack
    import rv_inst_encoder_pkg::*;
(
    input  fmt_e        fmt,
    input  logic [63:0] imm,
    output logic [31:0] imm_bits,
    output logic        imm_ok
);

    always_comb begin
        imm_bits = '0;
        imm_ok   = 1'b1;
        case (fmt)
            FMT_I: begin
                imm_ok   = fits_signed(imm, 12);
                imm_bits = {imm[11:0], 20'b0};
            end
            FMT_SH: begin
                imm_ok   = (imm[63:6] == '0);
                imm_bits = {6'b0, imm[5:0], 20'b0};
            end
            FMT_S: begin
                imm_ok   = fits_signed(imm, 12);
                imm_bits = {imm[11:5], 13'b0, imm[4:0], 7'b0};
            end
            FMT_B: begin
                imm_ok   = fits_signed(imm, 13) && !imm[0];
                imm_bits = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
            end
            FMT_J: begin
                imm_ok   = fits_signed(imm, 21) && !imm[0];
                imm_bits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
            end
            FMT_U: begin
                imm_ok   = (imm[11:0] == '0) && fits_signed(imm, 32);
                imm_bits = {imm[31:12], 12'b0};
            end
            default: begin
                imm_ok   = 1'b1;
                imm_bits = '0;
            end
        endcase
    end

endmodule

// File: rtl/rv_inst_encoder.sv
// Symbolic request -> RV64I machine word encoder with LI pseudo-op expansion
// and a registered valid/ready output stage.
module rv_inst_encoder
    import rv_inst_encoder_pkg::*;
#(
    parameter int unsigned OP_W  = 6,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [63:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic             out_last,
    output logic [CNT_W-1:0] emit_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_HOLD2} state_e;

    state_e           state_q, state_d;
    enc_word_t        word_q, word_d;
    logic [31:0]      pend_q, pend_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    enc_op_e     op;
    logic        op_hi_ok;
    fmt_e        fmt;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        known;
    logic        is_li;

    logic        li_fits12;
    logic        li_ok;
    logic        li_two;
    logic [19:0] li_hi;

    fmt_e        pack_fmt;
    logic [63:0] pack_imm;
    logic [31:0] pack_bits;
    logic        pack_ok;
    logic [6:0]  opc_eff;
    logic [4:0]  rs1_eff;
    logic [31:0] inst0;
    logic [31:0] inst1;
    logic        req_err;
    logic        req_two;
    logic        accept;
    logic        handoff;

    assign op       = enc_op_e'(6'(in_op));
    assign op_hi_ok = (in_op == OP_W'(6'(in_op)));

    // Per-op format and fixed fields.
    always_comb begin
        fmt   = FMT_R;
        opc   = OPC_OP;
        f3    = F3_ADD;
        f7    = F7_BASE;
        known = 1'b1;
        is_li = 1'b0;
        case (op)
            ENC_ADDI:   begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_ADD;  end
            ENC_SLTI:   begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_SLT;  end
            ENC_SLTIU:  begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_SLTU; end
            ENC_ANDI:   begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_AND;  end
            ENC_ORI:    begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_OR;   end
            ENC_XORI:   begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_XOR;  end
            ENC_SLLI:   begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = F3_SLL;  end
            ENC_SRLI:   begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = F3_SR;   end
            ENC_SRAI:   begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = F3_SR; f7 = F7_ALT; end
            ENC_JALR:   begin fmt = FMT_I;  opc = OPC_JALR;   f3 = F3_ADD;  end
            ENC_LD:     begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = F3_LD;   end
            ENC_SD:     begin fmt = FMT_S;  opc = OPC_STORE;  f3 = F3_SD;   end
            ENC_BEQ:    begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BEQ;  end
            ENC_BNE:    begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BNE;  end
            ENC_BLT:    begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BLT;  end
            ENC_BGE:    begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BGE;  end
            ENC_BLTU:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BLTU; end
            ENC_BGEU:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BGEU; end
            ENC_JAL:    begin fmt = FMT_J;  opc = OPC_JAL;   end
            ENC_LUI:    begin fmt = FMT_U;  opc = OPC_LUI;   end
            ENC_AUIPC:  begin fmt = FMT_U;  opc = OPC_AUIPC; end
            ENC_ADD:    begin f3 = F3_ADD;  end
            ENC_SUB:    begin f3 = F3_ADD;  f7 = F7_ALT; end
            ENC_SLT:    begin f3 = F3_SLT;  end
            ENC_SLTU:   begin f3 = F3_SLTU; end
            ENC_AND:    begin f3 = F3_AND;  end
            ENC_OR:     begin f3 = F3_OR;   end
            ENC_XOR:    begin f3 = F3_XOR;  end
            ENC_SLL:    begin f3 = F3_SLL;  end
            ENC_SRL:    begin f3 = F3_SR;   end
            ENC_SRA:    begin f3 = F3_SR;   f7 = F7_ALT; end
            ENC_EBREAK: begin fmt = FMT_SYS; opc = OPC_SYSTEM; end
            ENC_LI:     begin fmt = FMT_I;  opc = OPC_OP_IMM; is_li = 1'b1; end
            default:    known = 1'b0;
        endcase
    end

    // LI split: the excluded top window would round hi up past 0x7FFFF.
    assign li_fits12 = fits_signed(in_imm, 12);
    assign li_hi     = 20'((in_imm[31:0] + 32'h0000_0800) >> 12);
    assign li_ok     = fits_signed(in_imm, 32) && (in_imm[63:11] != 53'(20'hF_FFFF));
    assign li_two    = !li_fits12 && (in_imm[11:0] != 12'h000);

    assign pack_fmt = (is_li && !li_fits12) ? FMT_U : fmt;
    assign pack_imm = (is_li && !li_fits12) ? {{32{li_hi[19]}}, li_hi, 12'b0} : in_imm;
    assign opc_eff  = (is_li && !li_fits12) ? OPC_LUI : opc;
    assign rs1_eff  = is_li ? 5'd0 : in_rs1;

    rv_imm_pack u_imm_pack (
        .fmt      (pack_fmt),
        .imm      (pack_imm),
        .imm_bits (pack_bits),
        .imm_ok   (pack_ok)
    );

    // Merge register/funct fields according to the format.
    always_comb begin
        inst0 = pack_bits | 32'(opc_eff);
        case (pack_fmt)
            FMT_R:        inst0 = inst0 | {f7, in_rs2, rs1_eff, f3, in_rd, 7'b0};
            FMT_I:        inst0 = inst0 | {12'b0, rs1_eff, f3, in_rd, 7'b0};
            FMT_SH:       inst0 = inst0 | {f7, 5'b0, rs1_eff, f3, in_rd, 7'b0};
            FMT_S, FMT_B: inst0 = inst0 | {7'b0, in_rs2, rs1_eff, f3, 5'b0, 7'b0};
            FMT_J, FMT_U: inst0 = inst0 | {20'b0, in_rd, 7'b0};
            default:      inst0 = INST_EBREAK;
        endcase
    end

    assign inst1   = {in_imm[11:0], in_rd, F3_ADD, in_rd, OPC_OP_IMM};
    assign req_err = !known || !op_hi_ok || (is_li ? !li_ok : !pack_ok);
    assign req_two = is_li && li_ok && li_two;

    assign in_ready = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
    assign accept   = in_valid && in_ready;
    assign handoff  = valid_q && out_ready;

    // Next state and output-stage contents.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        pend_d  = pend_q;
        valid_d = valid_q;
        cnt_d   = cnt_q + CNT_W'(handoff);
        case (state_q)
            S_IDLE, S_HOLD: begin
                if (accept) begin
                    valid_d = 1'b1;
                    if (req_err) begin
                        word_d  = '{inst: 32'h0, err: 1'b1, last: 1'b1};
                        state_d = S_HOLD;
                    end else if (req_two) begin
                        word_d  = '{inst: inst0, err: 1'b0, last: 1'b0};
                        pend_d  = inst1;
                        state_d = S_HOLD2;
                    end else begin
                        word_d  = '{inst: inst0, err: 1'b0, last: 1'b1};
                        state_d = S_HOLD;
                    end
                end else if ((state_q == S_HOLD) && out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_HOLD2: begin
                if (out_ready) begin
                    word_d  = '{inst: pend_q, err: 1'b0, last: 1'b1};
                    pend_d  = '0;
                    state_d = S_HOLD;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            pend_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_inst  = word_q.inst;
    assign out_err   = word_q.err;
    assign out_last  = word_q.last;
    assign emit_cnt  = cnt_q;

endmodule

// File: tb/tb_rv_inst_encoder.sv
// Scoreboard bench for rv_inst_encoder: expected words queued at drive time,
// compared on handoff and while stalled.
module tb_rv_inst_encoder;
    import rv_inst_encoder_pkg::*;

    localparam int unsigned OP_W  = 6;
    localparam int unsigned CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [OP_W-1:0]  in_op = '0;
    logic [4:0]       in_rd = '0;
    logic [4:0]       in_rs1 = '0;
    logic [4:0]       in_rs2 = '0;
    logic [63:0]      in_imm = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_inst;
    logic             out_err;
    logic             out_last;
    logic [CNT_W-1:0] emit_cnt;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
        logic        last;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 0;
    logic [31:0] total_words = 0;
    int          cyc = 0;

    rv_inst_encoder #(.OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .out_last  (out_last),
        .emit_cnt  (emit_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            exp_cnt = 0;
        end else if (out_valid) begin
            if (q.size() == 0) begin
                if (out_ready) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word got inst=%h err=%b last=%b", out_inst, out_err, out_last);
                end
            end else begin
                checks++;
                if ({out_inst, out_err, out_last} !== q[0]) begin
                    errors++;
                    $display("FAIL %s got inst=%h err=%b last=%b want inst=%h err=%b last=%b",
                             out_ready ? "handoff_word" : "stall_hold", out_inst, out_err, out_last,
                             q[0].inst, q[0].err, q[0].last);
                end
                if (out_ready) begin
                    checks++;
                    if (emit_cnt !== exp_cnt) begin
                        errors++;
                        $display("FAIL emit_cnt_at_handoff got %0d want %0d", emit_cnt, exp_cnt);
                    end
                    void'(q.pop_front());
                    exp_cnt++;
                end
            end
        end
    end

    task automatic expect_word(input logic [31:0] inst, input logic err, input logic last);
        q.push_back({inst, err, last});
        total_words++;
    endtask

    // Presents one request and returns at posedge+1 after it is accepted.
    task automatic drive(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [63:0] imm);
        int n;
        n = 0;
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout op=%0d in_ready=%b want 1", op, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0 || out_valid) begin
            errors++;
            $display("FAIL drain_timeout queued=%0d out_valid=%b want 0 and 0", q.size(), out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (emit_cnt !== total_words) begin
            errors++;
            $display("FAIL emit_cnt_total got %0d want %0d", emit_cnt, total_words);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({out_valid, out_inst, out_err, out_last} !== 35'h0 || emit_cnt !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got v=%b inst=%h err=%b last=%b cnt=%0d rdy=%b want 0 0 0 0 0 1",
                     out_valid, out_inst, out_err, out_last, emit_cnt, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        expect_word(32'h0050_0093, 1'b0, 1'b1);
        drive(ENC_ADDI, 5'd1, 5'd0, 5'd0, 64'd5);
        checks++;
        if (out_valid !== 1'b1 || out_inst !== 32'h0050_0093 || emit_cnt !== 32'd0) begin
            errors++;
            $display("FAIL single_latency got v=%b inst=%h cnt=%0d want 1 00500093 0", out_valid, out_inst, emit_cnt);
        end
        drain();
        checks++;
        if (emit_cnt !== 32'd1) begin
            errors++;
            $display("FAIL single_count got %0d want 1", emit_cnt);
        end
    endtask

    task automatic test_formats();
        out_ready = 1'b1;
        expect_word(32'h0021_B423, 1'b0, 1'b1); drive(ENC_SD,     5'd0, 5'd3, 5'd2, 64'd8);
        expect_word(32'h0010_0073, 1'b0, 1'b1); drive(ENC_EBREAK, 5'd7, 5'd9, 5'd4, 64'd123);
        expect_word(32'h4031_5093, 1'b0, 1'b1); drive(ENC_SRAI,   5'd1, 5'd2, 5'd0, 64'd3);
        expect_word(32'h4020_81B3, 1'b0, 1'b1); drive(ENC_SUB,    5'd3, 5'd1, 5'd2, 64'd999);
        expect_word(32'hFE20_8CE3, 1'b0, 1'b1); drive(ENC_BEQ,    5'd0, 5'd1, 5'd2, -64'sd8);
        expect_word(32'h0010_00EF, 1'b0, 1'b1); drive(ENC_JAL,    5'd1, 5'd0, 5'd0, 64'd2048);
        expect_word(32'h8000_0137, 1'b0, 1'b1); drive(ENC_LUI,    5'd2, 5'd0, 5'd0, 64'hFFFF_FFFF_8000_0000);
        expect_word(32'hFFF1_3203, 1'b0, 1'b1); drive(ENC_LD,     5'd4, 5'd2, 5'd0, -64'sd1);
        expect_word(32'h8000_0093, 1'b0, 1'b1); drive(ENC_ADDI,   5'd1, 5'd0, 5'd0, -64'sd2048);
        expect_word(32'h7E00_5FE3, 1'b0, 1'b1); drive(ENC_BGE,    5'd0, 5'd0, 5'd0, 64'd4094);
        drain();
    endtask

    task automatic test_errors();
        out_ready = 1'b1;
        expect_word(32'h0, 1'b1, 1'b1); drive(ENC_BEQ,  5'd0, 5'd1, 5'd2, 64'd3);
        expect_word(32'h0, 1'b1, 1'b1); drive(ENC_ADDI, 5'd1, 5'd0, 5'd0, 64'd4096);
        expect_word(32'h0, 1'b1, 1'b1); drive(ENC_SLLI, 5'd1, 5'd1, 5'd0, 64'd64);
        expect_word(32'h0, 1'b1, 1'b1); drive(ENC_SRAI, 5'd1, 5'd1, 5'd0, -64'sd1);
        expect_word(32'h0, 1'b1, 1'b1); drive(ENC_LUI,  5'd1, 5'd0, 5'd0, 64'h123);
        expect_word(32'h0, 1'b1, 1'b1); drive(ENC_JAL,  5'd1, 5'd0, 5'd0, 64'h10_0000);
        expect_word(32'h0, 1'b1, 1'b1); drive(ENC_BNE,  5'd0, 5'd1, 5'd2, 64'd4096);
        expect_word(32'h0, 1'b1, 1'b1); drive(6'd63,    5'd1, 5'd1, 5'd1, 64'd0);
        expect_word(32'h0, 1'b1, 1'b1); drive(ENC_LI,   5'd1, 5'd0, 5'd0, 64'h7FFF_F800);
        expect_word(32'h0, 1'b1, 1'b1); drive(ENC_LI,   5'd1, 5'd0, 5'd0, 64'h1_0000_0000);
        drain();
    endtask

    task automatic test_li();
        out_ready = 1'b0;
        expect_word(32'h1234_52B7, 1'b0, 1'b0);
        expect_word(32'h6782_8293, 1'b0, 1'b1);
        drive(ENC_LI, 5'd5, 5'd0, 5'd0, 64'h1234_5678);
        checks++;
        if (out_valid !== 1'b1 || out_last !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL li_hold2 got v=%b last=%b rdy=%b want 1 0 0", out_valid, out_last, in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_inst !== 32'h1234_52B7) begin
            errors++;
            $display("FAIL li_hold2_stall got rdy=%b inst=%h want 0 123452b7", in_ready, out_inst);
        end
        out_ready = 1'b1;
        drain();
        expect_word(32'hFFB0_0093, 1'b0, 1'b1); drive(ENC_LI, 5'd1, 5'd0, 5'd0, -64'sd5);
        expect_word(32'h1234_52B7, 1'b0, 1'b1); drive(ENC_LI, 5'd5, 5'd0, 5'd0, 64'h1234_5000);
        expect_word(32'h7FFF_F0B7, 1'b0, 1'b0);
        expect_word(32'h7FF0_8093, 1'b0, 1'b1); drive(ENC_LI, 5'd1, 5'd0, 5'd0, 64'h7FFF_F7FF);
        expect_word(32'h0000_10B7, 1'b0, 1'b0);
        expect_word(32'h8000_8093, 1'b0, 1'b1); drive(ENC_LI, 5'd1, 5'd0, 5'd0, 64'h800);
        expect_word(32'hEDCB_B0B7, 1'b0, 1'b0);
        expect_word(32'h9880_8093, 1'b0, 1'b1); drive(ENC_LI, 5'd1, 5'd0, 5'd0, 64'hFFFF_FFFF_EDCB_A988);
        drain();
    endtask

    task automatic test_back_to_back();
        int start;
        out_ready = 1'b1;
        start = cyc;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [11:0] imm12;
                    imm12 = 12'(i * 7);
                    expect_word({imm12, 5'd0, 3'b000, 5'(i + 1), 7'h13}, 1'b0, 1'b1);
                    drive(ENC_ADDI, 5'(i + 1), 5'd0, 5'd0, 64'(i * 7));
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (cyc - start > 16) begin
            errors++;
            $display("FAIL b2b_rate got %0d cycles want at most 16", cyc - start);
        end
    endtask

    task automatic test_reset_hold2();
        out_ready = 1'b0;
        expect_word(32'h1234_52B7, 1'b0, 1'b0);
        expect_word(32'h6782_8293, 1'b0, 1'b1);
        drive(ENC_LI, 5'd5, 5'd0, 5'd0, 64'h1234_5678);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || emit_cnt !== '0 || out_last !== 1'b0 || out_inst !== 32'h0) begin
            errors++;
            $display("FAIL reset_hold2 got v=%b cnt=%0d last=%b inst=%h want 0 0 0 0", out_valid, emit_cnt, out_last, out_inst);
        end
        total_words = 0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || emit_cnt !== '0) begin
                errors++;
                $display("FAIL reset_no_pending got v=%b cnt=%0d want 0 0", out_valid, emit_cnt);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_formats();
        test_errors();
        test_li();
        test_back_to_back();
        test_reset_hold2();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected got %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
